// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the multiply/divide unit: op codes,
//               default operand width, FSM state type and op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Op encodings shared with the decoder and hazard unit
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // True for the four iterative ops (MULT/MULTU/DIV/DIVU)
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Issue/result bundle between the EX stage and the
//               multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues ops and reads HI/LO
  modport master (
    output start, op, rs_val, rt_val, cancel,
    input  busy, done, hi, lo
  );

  // Unit side
  modport slave (
    input  start, op, rs_val, rt_val, cancel,
    output busy, done, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration on magnitudes.
//               Mult: shift-add on {hi,lo}, lo holds the remaining multiplier.
//               Div : restoring shift-subtract, hi = partial remainder,
//                     lo = dividend shifting out / quotient shifting in.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] op_a_i,   // multiplicand or divisor magnitude
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;

  // Single iteration: carry of the add is kept so the right shift loses nothing
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, op_a_i} : '0);
    shifted = {hi_i, lo_i[WIDTH-1]};
    // The true difference is below the divisor, so WIDTH bits hold it exactly
    rem_sub = shifted[WIDTH-1:0] - op_a_i;
    hi_o    = hi_i;
    lo_o    = lo_i;
    if (is_div_i) begin
      if (shifted >= {1'b0, op_a_i}) begin
        hi_o = rem_sub;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit producing HI/LO. WIDTH
//               iteration cycles plus one sign-fixup cycle; MTHI/MTLO are
//               single-cycle writes from IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic             op_signed;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign op_signed = is_signed_op(bus.op);
  assign rs_mag    = (op_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign rt_mag    = (op_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_neg  = -prod;

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .op_a_i   (opa_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: cancel only matters once an op is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start && is_muldiv(bus.op)) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.cancel)             state_d = ST_IDLE;
        else if (count_q == LAST)   state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand latch, iteration, sign fixup, HI/LO writes
  always_comb begin
    count_d   = count_q;
    opa_d     = opa_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_muldiv(bus.op)) begin
            is_div_d  = is_div_op(bus.op);
            opa_d     = is_div_op(bus.op) ? rt_mag : rs_mag;
            acc_lo_d  = is_div_op(bus.op) ? rs_mag : rt_mag;
            acc_hi_d  = '0;
            count_d   = '0;
            neg_res_d = op_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
            neg_rem_d = op_signed && bus.rs_val[WIDTH-1];
            div0_d    = (bus.rt_val == '0);
          end else if (bus.op == MD_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.op == MD_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      ST_CALC: begin
        if (!bus.cancel) begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          count_d  = count_q + CW'(1);
        end
      end
      ST_FIX: begin
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero keeps the all-ones quotient; the remainder
            // sign fix then reproduces the original dividend.
            lo_d = div0_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end else begin
            {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      opa_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      opa_q     <= opa_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model of HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] mhi, mlo;   // model HI/LO

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi,lo} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa  = 64'(signed'(a));
    sb  = 64'(signed'(b));
    res = '0;
    case (op)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == MD_DIV) begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
      default: res = {mhi, mlo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one mult/div and check latency, busy length, result and done pulse
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit busy_poke, input bit cancel_poke);
    logic [63:0] exp;
    int n, busy_cnt;
    bit seen;
    exp = ref_result(op, a, b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.cancel = cancel_poke;
    n = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      if (busy_poke && n == 5) begin
        bus.start  = 1'b1;
        bus.op     = MD_MULT;
        bus.rs_val = 32'($urandom);
        bus.rt_val = 32'($urandom);
      end
    end
    check({tag, ".lat"}, 64'(n), 64'd34);
    check({tag, ".busy"}, 64'(busy_cnt), 64'd33);
    check({tag, ".hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, ".lo"}, 64'(bus.lo), 64'(exp[31:0]));
    mhi = exp[63:32];
    mlo = exp[31:0];
    @(negedge clk);
    check({tag, ".pulse"}, 64'(bus.done), 64'd0);
  endtask

  // Start a MULT, then abandon it at cycle 10 by cancel or by reset
  task automatic abort_op(input string tag, input bit use_reset);
    int done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = MD_MULT;
    bus.rs_val = 32'($urandom);
    bus.rt_val = 32'($urandom);
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (use_reset) rst_n = 1'b0;
    else           bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    rst_n      = 1'b1;
    if (use_reset) begin
      mhi = '0;
      mlo = '0;
    end
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(mhi));
    check({tag, ".lo"}, 64'(bus.lo), 64'(mlo));
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check({tag, ".nodone"}, 64'(done_cnt), 64'd0);
    check({tag, ".hold"}, {32'(bus.hi), 32'(bus.lo)}, {mhi, mlo});
  endtask

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Stimulus sequence
  initial begin
    logic [2:0] rop;
    total = 0; bad = 0;
    mhi = '0; mlo = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rs_val = '0; bus.rt_val = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;

    run_op("mult",   MD_MULT,  32'hFFFF_FFF0, 32'h7FFF_FFF1, 1'b0, 1'b0);
    run_op("multu",  MD_MULTU, 32'hFFFF_FFF0, 32'h7FFF_FFF1, 1'b0, 1'b0);
    run_op("divu",   MD_DIVU,  32'hFFFF_FFF0, 32'h7FFF_FFF1, 1'b0, 1'b0);
    run_op("div",    MD_DIV,   32'hFFFF_FFF0, 32'h7FFF_FFF1, 1'b0, 1'b0);
    run_op("div_m7", MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op("div0",   MD_DIV,   32'h0000_1234, 32'd0,         1'b0, 1'b0);
    run_op("divu0",  MD_DIVU,  32'h8000_0001, 32'd0,         1'b0, 1'b0);
    run_op("ovf",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("poke",   MD_MULT,  32'h0001_2345, 32'hFFFF_FF00, 1'b1, 1'b0);
    run_op("cstart", MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);

    // Back-to-back MTHI then MTLO
    @(negedge clk);
    bus.start = 1'b1; bus.op = MD_MTHI; bus.rs_val = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi.hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
    check("mthi.lo", 64'(bus.lo), 64'(mlo));
    check("mthi.busy", 64'(bus.busy), 64'd0);
    check("mthi.done", 64'(bus.done), 64'd0);
    bus.op = MD_MTLO; bus.rs_val = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo.lo", 64'(bus.lo), 64'h0000_0000_5A5A_5A5A);
    check("mtlo.hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
    check("mtlo.busy", 64'(bus.busy), 64'd0);
    check("mtlo.done", 64'(bus.done), 64'd0);
    mhi = 32'hA5A5_A5A5;
    mlo = 32'h5A5A_5A5A;

    // Undefined op code in IDLE
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.rs_val = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.start = 1'b0;
    check("undef.busy", 64'(bus.busy), 64'd0);
    check("undef.hilo", {32'(bus.hi), 32'(bus.lo)}, {mhi, mlo});
    @(negedge clk);
    check("undef.done", 64'(bus.done), 64'd0);

    abort_op("cancel", 1'b0);
    run_op("after_cancel", MD_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b0);
    abort_op("midrst", 1'b1);
    run_op("after_rst", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      run_op("rand", rop, pick(), pick(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
